nios2_prog_reset_debounce: RTL and testbench
============================================

# nios2_prog_reset_debounce

Per-bit input conditioner for the programmable-reset/key inputs of the Nios II system. It synchronises raw asynchronous board inputs into `clk`, optionally inverts them, and debounces each bit with its own counter. It drives the 8-bit `in_port` of the Prog_reset PIO with a clean, glitch-free level vector, and sits directly upstream of that PIO.

## Interface
- `WIDTH`, 8: number of independent input bits.
- `DEBOUNCE_CYCLES`, 500000: consecutive stable cycles required to accept a new level (10 ms at 50 MHz); must be ≥ 2.
- `SYNC_STAGES`, 2: synchroniser depth; must be ≥ 2.
- `ACTIVE_LOW`, 1: 1 means raw inputs are inverted before synchronisation, so a pressed key reads as 1.

- `clk`  in  1  system clock. Single clock domain.
- `reset`  in  1  synchronous, active-high reset.
- `raw_in`  in  WIDTH  asynchronous raw key/switch inputs.
- `level_out`  out  WIDTH  debounced level; connects to the PIO `in_port`.
- `rise_pulse`  out  WIDTH  one-cycle strobe per bit on a debounced 0→1 transition.
- `stable`  out  1  high when no bit is mid-debounce.

## Operation
- Input path per bit:
  - polarity: `p = raw_in ^ ACTIVE_LOW`.
  - `p` passes through a `SYNC_STAGES`-deep flop chain, giving `s`.
- Per-bit counter `cnt`, width `$clog2(DEBOUNCE_CYCLES)`, unsigned.
- Per-bit two-state machine:
  - IDLE (`s == level_out`): `cnt` held at 0.
  - COUNT (`s != level_out`): `cnt` increments each cycle.
  - Mismatch clears: return to IDLE and set `cnt` = 0 on the same edge. A partial count is never retained.
  - `cnt == DEBOUNCE_CYCLES-1` with mismatch still present: on that edge, `level_out` ← `s`, `cnt` ← 0, return to IDLE.
- `cnt` never exceeds `DEBOUNCE_CYCLES-1`, so it cannot wrap.
- Bits are fully independent. Simultaneous changes on several bits proceed in parallel and may commit on the same edge.
- `stable` = NOR of all per-bit COUNT flags, registered.
- `rise_pulse[i]` is asserted on the same edge that `level_out[i]` goes 0→1, for exactly one cycle. A 1→0 commit produces no pulse.

## Timing
- Reset values, applied on the first `clk` edge with `reset` = 1:
  - synchroniser flops: 0
  - `cnt`: 0
  - `level_out`: 0
  - `rise_pulse`: 0
  - `stable`: 1
- Reset mid-count discards the count. After release, a full `DEBOUNCE_CYCLES` run is required again.
- Latency from a `raw_in` change (ideal, held) to `level_out`: `SYNC_STAGES + DEBOUNCE_CYCLES` clock edges.
- Glitch rejection: any post-synchroniser mismatch shorter than `DEBOUNCE_CYCLES` cycles is suppressed entirely.
- `stable` lags the COUNT flags by 1 cycle:
  - falls 1 cycle after the first mismatch cycle;
  - rises 1 cycle after the commit.
- `level_out` is registered and changes only on `clk` edges. The PIO samples it one cycle later; no handshake is required.

## Configuration
- `NIOS2_PROG_RESET_PULSE_EN`
  - Defined: rise-edge detect flops and `rise_pulse` logic are built as described above.
  - Undefined: that logic is not built. `rise_pulse` remains on the port list, tied to all zeros. `level_out` and `stable` behaviour is unchanged.

## Structure
- Package `nios2_prog_reset_pkg`:
  - default constants: `DEBOUNCE_CYCLES`, `SYNC_STAGES`;
  - counter-width function;
  - `state_t` enum {IDLE, COUNT}.
- Sub-module `nios2_debounce_bit` (synchroniser, counter, FSM, optional edge detect for one bit). The top instantiates `WIDTH` copies in a generate loop and builds `stable` from their COUNT flags.

## Test plan
Bench parameters: `DEBOUNCE_CYCLES=16`, `SYNC_STAGES=2`, `ACTIVE_LOW=1`, macro defined.

1. Reset: hold `reset` 3 cycles with `raw_in=8'hFF`, release → `level_out=8'h00`, `rise_pulse=0`, `stable=1`, all unchanged for 50 cycles.
2. Clean press: `raw_in[0]` 1→0 and held → `level_out[0]` rises exactly 18 edges later. `rise_pulse[0]` is high for that one cycle only. `stable` is low for 16 cycles.
3. Bounce and glitch:
   - `raw_in[3]` toggles every 5 cycles for 40 cycles, then holds low → `level_out[3]` stays 0 throughout, then rises 18 edges after the final edge.
   - A 15-cycle low glitch on `raw_in[3]` → no change.
4. Release: `level_out[0]=1`, then `raw_in[0]` 0→1 and held → `level_out[0]` falls after 18 edges, with no `rise_pulse`.
5. Reset mid-count: assert `reset` when bit 2 `cnt`=10 → `level_out[2]=0`, `stable=1`. With the input still held after release, `level_out[2]` rises 18 edges later.
6. Simultaneous: `raw_in[0]` and `raw_in[7]` fall on the same cycle → both `level_out` bits and both `rise_pulse` bits assert on the same edge.

Source files
------------

// File: rtl/nios2_prog_reset_pkg.sv
// Shared constants, state type and counter-width helper for the
// programmable-reset/key input conditioner.
package nios2_prog_reset_pkg;

   localparam int DEBOUNCE_CYCLES = 500000;
   localparam int SYNC_STAGES     = 2;

   typedef enum logic {
      IDLE  = 1'b0,
      COUNT = 1'b1
   } state_t;

   // Width that holds 0 .. cycles-1.
   function automatic int cnt_width(input int cycles);
      return (cycles > 1) ? $clog2(cycles) : 1;
   endfunction

endpackage

// File: rtl/nios2_prog_reset_debounce_if.sv
// Key-conditioner bundle: raw board inputs in, clean levels out.
// Ports: raw_in, level_out, rise_pulse, stable.
interface nios2_prog_reset_debounce_if #(
   parameter int WIDTH = 8
);

   logic [WIDTH-1:0] raw_in;
   logic [WIDTH-1:0] level_out;
   logic [WIDTH-1:0] rise_pulse;
   logic             stable;

   modport master (
      output raw_in,
      input  level_out,
      input  rise_pulse,
      input  stable
   );

   modport slave (
      input  raw_in,
      output level_out,
      output rise_pulse,
      output stable
   );

endinterface

// File: rtl/nios2_debounce_bit.sv
// One-bit conditioner: polarity, synchroniser, debounce FSM, edge strobe.
// Ports: clk, reset, raw_in -> level_out, rise_pulse, counting.
// Macro NIOS2_PROG_RESET_PULSE_EN builds the rise strobe.
module nios2_debounce_bit #(
   parameter int DEBOUNCE_CYCLES = nios2_prog_reset_pkg::DEBOUNCE_CYCLES,
   parameter int SYNC_STAGES     = nios2_prog_reset_pkg::SYNC_STAGES,
   parameter bit ACTIVE_LOW      = 1'b1
) (
   input  logic clk,
   input  logic reset,
   input  logic raw_in,
   output logic level_out,
   output logic rise_pulse,
   output logic counting
);

   import nios2_prog_reset_pkg::*;

   localparam int CW = cnt_width(DEBOUNCE_CYCLES);
   localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   s;
   state_t                 state_q;
   state_t                 state_d;
   logic [CW-1:0]          cnt_q;
   logic [CW-1:0]          cnt_d;
   logic                   level_q;
   logic                   level_d;
   logic                   commit;

   always_ff @(posedge clk) begin
      if (reset) begin
         sync_q <= '0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], raw_in ^ ACTIVE_LOW};
      end
   end

   assign s        = sync_q[SYNC_STAGES-1];
   // Mismatch is the live COUNT condition; it drives `stable` upstream.
   assign counting = s ^ level_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         level_q <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         level_q <= level_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      commit  = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (counting) begin
               state_d = COUNT;
               cnt_d   = CW'(1);
            end
         end
         COUNT: begin
            if (!counting) begin
               // Partial counts are never kept.
               state_d = IDLE;
               cnt_d   = '0;
            end else if (cnt_q == CNT_MAX) begin
               state_d = IDLE;
               cnt_d   = '0;
               commit  = 1'b1;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: begin
            state_d = IDLE;
            cnt_d   = '0;
         end
      endcase
      level_d = commit ? s : level_q;
   end

   assign level_out = level_q;

`ifdef NIOS2_PROG_RESET_PULSE_EN
   logic rise_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         rise_q <= 1'b0;
      end else begin
         rise_q <= commit & s;
      end
   end

   assign rise_pulse = rise_q;
`else
   assign rise_pulse = 1'b0;
`endif

endmodule

// File: rtl/nios2_prog_reset_debounce.sv
// Per-bit key conditioner feeding the Prog_reset PIO in_port.
// Ports: clk, reset, bus (raw_in, level_out, rise_pulse, stable).
// Macro NIOS2_PROG_RESET_PULSE_EN enables rise_pulse strobes.
module nios2_prog_reset_debounce #(
   parameter int WIDTH           = 8,
   parameter int DEBOUNCE_CYCLES = nios2_prog_reset_pkg::DEBOUNCE_CYCLES,
   parameter int SYNC_STAGES     = nios2_prog_reset_pkg::SYNC_STAGES,
   parameter bit ACTIVE_LOW      = 1'b1
) (
   input  logic                        clk,
   input  logic                        reset,
   nios2_prog_reset_debounce_if.slave  bus
);

   import nios2_prog_reset_pkg::*;

   logic [WIDTH-1:0] counting;
   logic [WIDTH-1:0] level;
   logic [WIDTH-1:0] rise;
   logic             stable_q;

   for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      nios2_debounce_bit #(
         .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
         .SYNC_STAGES     (SYNC_STAGES),
         .ACTIVE_LOW      (ACTIVE_LOW)
      ) u_bit (
         .clk        (clk),
         .reset      (reset),
         .raw_in     (bus.raw_in[i]),
         .level_out  (level[i]),
         .rise_pulse (rise[i]),
         .counting   (counting[i])
      );
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         stable_q <= 1'b1;
      end else begin
         stable_q <= ~|counting;
      end
   end

   assign bus.level_out  = level;
   assign bus.rise_pulse = rise;
   assign bus.stable     = stable_q;

endmodule

// File: tb/tb_nios2_prog_reset_debounce.sv
// Directed bench for nios2_prog_reset_debounce.
// DEBOUNCE_CYCLES=16, SYNC_STAGES=2, ACTIVE_LOW=1.
module tb_nios2_prog_reset_debounce;

`ifdef NIOS2_PROG_RESET_PULSE_EN
   localparam bit PULSE_EN = 1'b1;
`else
   localparam bit PULSE_EN = 1'b0;
`endif

   logic clk = 1'b0;
   logic reset = 1'b1;
   int   checks = 0;
   int   errors = 0;

   nios2_prog_reset_debounce_if #(.WIDTH(8)) bus();

   nios2_prog_reset_debounce #(
      .WIDTH           (8),
      .DEBOUNCE_CYCLES (16),
      .SYNC_STAGES     (2),
      .ACTIVE_LOW      (1'b1)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      bus.raw_in = 8'hFF;
      reset = 1'b1;
      repeat (3) tick();
      reset = 1'b0;
      checks++;
      if (bus.level_out !== 8'h00) begin
         errors++;
         $display("FAIL reset_level got %h exp 00", bus.level_out);
      end
      checks++;
      if (bus.rise_pulse !== 8'h00) begin
         errors++;
         $display("FAIL reset_rise got %h exp 00", bus.rise_pulse);
      end
      checks++;
      if (bus.stable !== 1'b1) begin
         errors++;
         $display("FAIL reset_stable got %b exp 1", bus.stable);
      end
      for (int k = 1; k <= 50; k++) begin
         tick();
         checks++;
         if ({bus.level_out, bus.rise_pulse, bus.stable}
             !== {8'h00, 8'h00, 1'b1}) begin
            errors++;
            $display("FAIL reset_hold k=%0d got %h/%h/%b exp 00/00/1",
                     k, bus.level_out, bus.rise_pulse, bus.stable);
         end
      end
   endtask

   task automatic test_clean_press();
      logic [7:0] el;
      logic [7:0] er;
      logic       es;
      bus.raw_in[0] = 1'b0;
      for (int k = 1; k <= 20; k++) begin
         tick();
         el = (k >= 18) ? 8'h01 : 8'h00;
         er = (PULSE_EN && k == 18) ? 8'h01 : 8'h00;
         es = (k < 3) || (k >= 19);
         checks++;
         if (bus.level_out !== el) begin
            errors++;
            $display("FAIL press_level k=%0d got %h exp %h",
                     k, bus.level_out, el);
         end
         checks++;
         if (bus.rise_pulse !== er) begin
            errors++;
            $display("FAIL press_rise k=%0d got %h exp %h",
                     k, bus.rise_pulse, er);
         end
         checks++;
         if (bus.stable !== es) begin
            errors++;
            $display("FAIL press_stable k=%0d got %b exp %b",
                     k, bus.stable, es);
         end
      end
   endtask

   task automatic test_glitch();
      bus.raw_in[3] = 1'b0;
      for (int k = 1; k <= 40; k++) begin
         if (k == 16) bus.raw_in[3] = 1'b1;
         tick();
         checks++;
         if ({bus.level_out, bus.rise_pulse} !== {8'h01, 8'h00}) begin
            errors++;
            $display("FAIL glitch k=%0d got %h/%h exp 01/00",
                     k, bus.level_out, bus.rise_pulse);
         end
      end
   endtask

   task automatic test_bounce();
      logic [7:0] el;
      logic [7:0] er;
      for (int j = 0; j < 8; j++) begin
         bus.raw_in[3] = (j % 2 == 1);
         for (int k = 0; k < 5; k++) begin
            tick();
            checks++;
            if (bus.level_out !== 8'h01) begin
               errors++;
               $display("FAIL bounce_hold j=%0d got %h exp 01",
                        j, bus.level_out);
            end
         end
      end
      bus.raw_in[3] = 1'b0;
      for (int k = 1; k <= 20; k++) begin
         tick();
         el = (k >= 18) ? 8'h09 : 8'h01;
         er = (PULSE_EN && k == 18) ? 8'h08 : 8'h00;
         checks++;
         if (bus.level_out !== el) begin
            errors++;
            $display("FAIL bounce_level k=%0d got %h exp %h",
                     k, bus.level_out, el);
         end
         checks++;
         if (bus.rise_pulse !== er) begin
            errors++;
            $display("FAIL bounce_rise k=%0d got %h exp %h",
                     k, bus.rise_pulse, er);
         end
      end
      bus.raw_in[3] = 1'b1;
      repeat (20) tick();
      checks++;
      if (bus.level_out !== 8'h01) begin
         errors++;
         $display("FAIL bounce_clear got %h exp 01", bus.level_out);
      end
   endtask

   task automatic test_release();
      logic [7:0] el;
      bus.raw_in[0] = 1'b1;
      for (int k = 1; k <= 20; k++) begin
         tick();
         el = (k < 18) ? 8'h01 : 8'h00;
         checks++;
         if (bus.level_out !== el) begin
            errors++;
            $display("FAIL release_level k=%0d got %h exp %h",
                     k, bus.level_out, el);
         end
         checks++;
         if (bus.rise_pulse !== 8'h00) begin
            errors++;
            $display("FAIL release_rise k=%0d got %h exp 00",
                     k, bus.rise_pulse);
         end
      end
   endtask

   task automatic test_reset_mid();
      logic el;
      bus.raw_in[2] = 1'b0;
      repeat (12) tick();
      checks++;
      if (bus.stable !== 1'b0) begin
         errors++;
         $display("FAIL midrst_pre got stable %b exp 0", bus.stable);
      end
      reset = 1'b1;
      tick();
      reset = 1'b0;
      checks++;
      if ({bus.level_out, bus.stable} !== {8'h00, 1'b1}) begin
         errors++;
         $display("FAIL midrst_reset got %h/%b exp 00/1",
                  bus.level_out, bus.stable);
      end
      for (int k = 1; k <= 20; k++) begin
         tick();
         el = (k >= 18);
         checks++;
         if (bus.level_out[2] !== el) begin
            errors++;
            $display("FAIL midrst_level k=%0d got %b exp %b",
                     k, bus.level_out[2], el);
         end
      end
      bus.raw_in = 8'hFF;
      repeat (20) tick();
      checks++;
      if (bus.level_out !== 8'h00) begin
         errors++;
         $display("FAIL midrst_clear got %h exp 00", bus.level_out);
      end
   endtask

   task automatic test_simultaneous();
      logic [7:0] el;
      logic [7:0] er;
      bus.raw_in = 8'h7E;
      for (int k = 1; k <= 20; k++) begin
         tick();
         el = (k >= 18) ? 8'h81 : 8'h00;
         er = (PULSE_EN && k == 18) ? 8'h81 : 8'h00;
         checks++;
         if (bus.level_out !== el) begin
            errors++;
            $display("FAIL simul_level k=%0d got %h exp %h",
                     k, bus.level_out, el);
         end
         checks++;
         if (bus.rise_pulse !== er) begin
            errors++;
            $display("FAIL simul_rise k=%0d got %h exp %h",
                     k, bus.rise_pulse, er);
         end
      end
   endtask

   initial begin
      bus.raw_in = 8'hFF;
      test_reset();
      test_clean_press();
      test_glitch();
      test_bounce();
      test_release();
      test_reset_mid();
      test_simultaneous();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
